// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
//
// Shared definitions for the run/stop, rate-select clock divider:
//   - state_t   : controller state encoding (IDLE, RUN, PEND)
//   - SEL_*     : 2-bit rate-select codes (1, 2, 5, 10 Hz)
//   - rateHz    : rate code -> output frequency in Hz
//   - halfCount : rate code -> half-period length in input clock cycles
//
// Optional feature macro used elsewhere in this block: CLK_DIV_TICK_EN.
// -----------------------------------------------------------------------------
package clk_div_pkg;

  // IDLE : output parked low, counter parked at 1
  // RUN  : free-running toggle at the current rate
  // PEND : still running at the current rate, waiting for the next falling
  //        edge of the output to apply a stored request
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  localparam logic [1:0] SEL_1HZ  = 2'b00;
  localparam logic [1:0] SEL_2HZ  = 2'b01;
  localparam logic [1:0] SEL_5HZ  = 2'b10;
  localparam logic [1:0] SEL_10HZ = 2'b11;

  // Output frequency for a rate code.
  function automatic int unsigned rateHz(input logic [1:0] sel);
    int unsigned f;
    case (sel)
      SEL_1HZ:  f = 1;
      SEL_2HZ:  f = 2;
      SEL_5HZ:  f = 5;
      default:  f = 10;
    endcase
    return f;
  endfunction

  // Number of input clock cycles in one half period of the output clock.
  // CLK_HZ is required to be a multiple of 20, so this division is exact for
  // every rate code.
  function automatic int unsigned halfCount(input logic [1:0] sel,
                                            input int unsigned clkHz);
    return clkHz / (2 * rateHz(sel));
  endfunction

endpackage : clk_div_pkg

// File: rtl/clk_div_core.sv
// -----------------------------------------------------------------------------
// clk_div_core
//
// Half-period counter and output toggle register of the clock divider.
// The counter runs 1..halfCnt; on reaching halfCnt the output toggles and the
// counter reloads to 1. While reload is high (or Rst is high) the counter is
// parked at 1 and the output is parked at 0.
//
// Ports:
//   Clk50MHz  in   system clock, rising edge
//   Rst       in   synchronous, active-high reset
//   halfCnt   in   [CNT_W] half-period length in cycles (must be >= 1)
//   en        in   counting enable
//   reload    in   park counter at 1 and output at 0 (wins over en)
//   ClkOut    out  divided clock, registered
//   fallStb   out  high in the cycle whose rising edge takes ClkOut 1 -> 0
//   riseStb   out  high in the cycle whose rising edge takes ClkOut 0 -> 1
// -----------------------------------------------------------------------------
module clk_div_core #(
  parameter int unsigned CNT_W = 25
) (
  input  logic             Clk50MHz,
  input  logic             Rst,
  input  logic [CNT_W-1:0] halfCnt,
  input  logic             en,
  input  logic             reload,
  output logic             ClkOut,
  output logic             fallStb,
  output logic             riseStb
);

  logic [CNT_W-1:0] cnt;
  logic             atEnd;
  logic             active;

  assign atEnd  = (cnt == halfCnt);
  assign active = en && !reload;

  // Strobes are combinational look-aheads of the toggle register, so a
  // consumer that registers them lines up with the new ClkOut value.
  assign riseStb = active && atEnd && !ClkOut;
  assign fallStb = active && atEnd &&  ClkOut;

  // NOTE: state registers use non-blocking assignments so every register in
  // the design samples pre-edge values; blocking here would create ordering
  // races between always_ff blocks.
  always_ff @(posedge Clk50MHz) begin
    if (Rst || reload) begin
      cnt    <= CNT_W'(1);
      ClkOut <= 1'b0;
    end else if (en) begin
      if (atEnd) begin
        cnt    <= CNT_W'(1);
        ClkOut <= ~ClkOut;
      end else begin
        cnt    <= cnt + CNT_W'(1);
      end
    end
  end

endmodule : clk_div_core

// File: rtl/clk_div_controller.sv
// -----------------------------------------------------------------------------
// clk_div_controller
//
// Run/stop and rate-select controller for the square-wave clock divider.
// Produces a 50 %-duty ClkOut at 1, 2, 5 or 10 Hz from the system clock.
// Configuration arrives over a valid/ready handshake; while running, a new
// request is held pending and applied only at the next falling edge of
// ClkOut, so the output never produces a runt pulse.
//
// Build option: define CLK_DIV_TICK_EN to add the `tick` output, a registered
// one-cycle pulse coincident with the first cycle ClkOut reads 1.
//
// Parameters:
//   CLK_HZ  input clock frequency in Hz, multiple of 20
//   CNT_W   counter width, must hold CLK_HZ/2
//
// Ports:
//   Clk50MHz  in   system clock, rising edge
//   Rst       in   synchronous, active-high reset
//   cfgValid  in   configuration request, held until accepted
//   cfgReady  out  controller can accept a configuration (low in PEND)
//   cfgSel    in   [2] rate select: 00=1 Hz, 01=2 Hz, 10=5 Hz, 11=10 Hz
//   cfgRun    in   1 = run at cfgSel, 0 = stop after the current period
//   ClkOut    out  divided clock, registered
//   tick      out  rise pulse (only with CLK_DIV_TICK_EN)
//   running   out  high in RUN and PEND
//   curSel    out  [2] rate currently being generated
// -----------------------------------------------------------------------------
module clk_div_controller
  import clk_div_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned CNT_W  = 25
) (
  input  logic       Clk50MHz,
  input  logic       Rst,
  input  logic       cfgValid,
  output logic       cfgReady,
  input  logic [1:0] cfgSel,
  input  logic       cfgRun,
  output logic       ClkOut,
`ifdef CLK_DIV_TICK_EN
  output logic       tick,
`endif
  output logic       running,
  output logic [1:0] curSel
);

  state_t           state;
  logic [1:0]       pendSel;
  logic             pendRun;
  logic             accept;
  logic [CNT_W-1:0] halfCnt;
  logic             fallStb;
  logic             riseStb;

  assign cfgReady = (state != PEND);
  assign running  = (state != IDLE);
  assign accept   = cfgValid && cfgReady;

  // curSel only changes while the counter is parked (IDLE) or at the very
  // edge where the counter reloads to 1, so the compare value never moves
  // underneath a partially completed half period.
  assign halfCnt = CNT_W'(halfCount(curSel, CLK_HZ));

  clk_div_core #(
    .CNT_W (CNT_W)
  ) u_core (
    .Clk50MHz (Clk50MHz),
    .Rst      (Rst),
    .halfCnt  (halfCnt),
    .en       (state != IDLE),
    .reload   (state == IDLE),
    .ClkOut   (ClkOut),
    .fallStb  (fallStb),
    .riseStb  (riseStb)
  );

  always_ff @(posedge Clk50MHz) begin
    if (Rst) begin
      state   <= IDLE;
      curSel  <= SEL_1HZ;
      pendSel <= SEL_1HZ;
      pendRun <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            curSel <= cfgSel;
            if (cfgRun) state <= RUN;
          end
        end
        RUN: begin
          // Every request goes through PEND, even one that repeats the
          // current rate, so a stop or change always lands on a full period.
          if (accept) begin
            pendSel <= cfgSel;
            pendRun <= cfgRun;
            state   <= PEND;
          end
        end
        PEND: begin
          // The falling toggle is the period boundary: the core reloads to
          // 1 and drives ClkOut low on this same edge.
          if (fallStb) begin
            curSel <= pendSel;
            state  <= pendRun ? RUN : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CLK_DIV_TICK_EN
  // Registered copy of the rise look-ahead: high exactly in the first cycle
  // ClkOut reads 1.
  always_ff @(posedge Clk50MHz) begin
    if (Rst) tick <= 1'b0;
    else     tick <= riseStb;
  end
`else
  logic unusedRiseStb;
  assign unusedRiseStb = riseStb;
`endif

endmodule : clk_div_controller

// File: doc/clk_div_controller.md
# clk_div_controller

Run/stop and rate-select controller for the board's square-wave clock divider, driven from the 50 MHz system clock. It generates a 50 %-duty output clock at 1, 2, 5 or 10 Hz. Rate changes arrive over a valid/ready configuration handshake. Each change is applied only at a full-period boundary, so the output never glitches or produces a runt pulse. It sits between the front-panel/UART control logic and every blinking, counting or debouncing block that consumes the slow clock.

## Interface
- `CLK_HZ`, 50_000_000: input clock frequency in Hz. Must be divisible by 20.
- `CNT_W`, 25: counter width. Must hold CLK_HZ/2.
- `Clk50MHz`  in  1  system clock. All logic is on its rising edge.
- `Rst`  in  1  synchronous, active-high reset.
- `cfgValid`  in  1  configuration request. Held stable until accepted.
- `cfgReady`  out  1  controller can accept a configuration.
- `cfgSel`  in  2  rate select: 00 = 1 Hz, 01 = 2 Hz, 10 = 5 Hz, 11 = 10 Hz.
- `cfgRun`  in  1  1 = run at `cfgSel`; 0 = stop after the current period.
- `ClkOut`  out  1  divided clock, registered.
- `tick`  out  1  one-cycle pulse when `ClkOut` rises. Present only with `CLK_DIV_TICK_EN`.
- `running`  out  1  high in RUN and PEND.
- `curSel`  out  2  rate currently being generated.

## Operation
- The half-period count is N(sel) = CLK_HZ / (2·f). At default parameters N = 25_000_000, 12_500_000, 5_000_000 and 2_500_000.
- Counter `cnt` runs from 1 to N. When `cnt == N`, `ClkOut` toggles and `cnt` reloads to 1. Otherwise `cnt` increments. No other wrap is allowed.
- A configuration is accepted on any cycle where `cfgValid && cfgReady`.
- `cfgReady` = (state != PEND). It is combinational from registered state.
- IDLE:
  - `ClkOut` = 0 and `cnt` = 1, both held.
  - Accept with run = 1: latch `curSel`, then go to RUN.
  - Accept with run = 0: latch `curSel`, stay in IDLE.
- RUN:
  - Free-running toggle at N(curSel).
  - Accept: store `pendSel`/`pendRun`, then go to PEND. `curSel` is unchanged.
- PEND:
  - Counting continues at the old N.
  - On the falling toggle (`cnt == N` and `ClkOut == 1`): `ClkOut` goes to 0, `cnt` goes to 1, and `curSel` takes `pendSel`.
  - Next state is RUN if `pendRun`, else IDLE.
- A request with the same rate still passes through PEND. There is no shortcut.
- `Rst` has priority over everything, including a same-cycle `cfgValid`.
- Reset values: state = IDLE, `ClkOut` = 0, `cnt` = 1, `curSel` = 00, `pendSel` = 00, `pendRun` = 0, `tick` = 0, `running` = 0, `cfgReady` = 1.

## Timing
- Acceptance in IDLE with run = 1 at edge k: first `ClkOut` rise at edge k+N(sel). After that, the output has exact 50 % duty at period 2N.
- Stop from RUN: `ClkOut` completes its current high phase. It falls at the end of that phase and stays at 0 from then on. No truncated high pulse is allowed.
- Rate change from RUN: the old rate finishes its current full period. The first new high phase begins N(new) cycles after the boundary fall.
- `cfgReady` drops the cycle after acceptance in RUN. It returns the cycle after the PEND boundary.
- `tick` is registered and coincident with the cycle in which `ClkOut` first reads 1.
- Reset mid-PEND discards the pending request. The output is 0 in the cycle after `Rst` is sampled high.

## Configuration
- `CLK_DIV_TICK_EN` defined: the `tick` port and its register exist.
- `CLK_DIV_TICK_EN` undefined: `tick` is absent from the port list. All other behaviour is identical.

## Structure
- Package `clk_div_pkg` contains:
  - the state encoding (IDLE, RUN, PEND);
  - localparams for the 2-bit rate codes;
  - the constant function `halfCount(sel, CLK_HZ)`.
- Sub-module `clk_div_core` is the counter and toggle register. Its inputs are half-count, enable and reload. Its outputs are `ClkOut`, the boundary-fall strobe and the rise strobe.
- The top level holds the handshake, the state machine and the pending registers.

## Test plan
All scenarios use CLK_HZ = 200, giving N = 100, 50, 20 and 10.
- Reset, then accept sel = 00, run = 1 -> `ClkOut` rises 100 cycles after acceptance. Period is 200 cycles with 100 high and 100 low. `running` = 1.
- Running at 1 Hz, accept sel = 11 mid high phase -> `cfgReady` = 0 until the old period ends. `curSel` switches at the fall. The next high phase starts 10 cycles later and lasts 10 cycles.
- Running, accept run = 0 -> the current high phase completes at full length. `ClkOut` stays 0 afterwards, and the state is IDLE with `running` = 0.
- Hold `cfgValid` through PEND with a second request -> the second request is accepted only on the first cycle after the boundary. It is never lost and never double-accepted.
- Assert `Rst` during PEND -> all outputs take their reset values on the next cycle, and the pending rate is never applied.
- With `CLK_DIV_TICK_EN` at sel = 10 -> exactly one `tick` per 40 cycles, aligned to each `ClkOut` rise.
